mem_arbiter: RTL and testbench

//  Shares the single SRAM port between two requesters: port 0 (cpu core, aBus/yBus side)
//  and port 1 (DMA / boot loader). Round-robin arbitration, then sequences one memory

---
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single asynchronous SRAM port.
// Each grant runs one SETUP / STROBE / DONE access with programmable wait states.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  clock,
  input  logic                  notReset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memDataOut,
  output logic                  memDataOE,
  input  logic [DATA_WIDTH-1:0] memDataIn,
  output logic                  memNotRead,
  output logic                  memNotWrite
);

  if (WAIT_STATES > 15) begin : g_ws_range
    $error("mem_arbiter: WAIT_STATES must be in 0..15");
  end

  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic                  op_we_q, op_we_d;
  logic                  last_gnt_q, last_gnt_d;
  logic                  gnt0_q, gnt0_d;
  logic                  gnt1_q, gnt1_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  oe_q, oe_d;
  logic                  nrd_q, nrd_d;
  logic                  nwr_q, nwr_d;
  logic                  pick1;

  // last_gnt holds the port number of the previous winner; a tie goes to the other port.
  assign pick1 = req1 && (!req0 || !last_gnt_q);

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    op_we_d    = op_we_q;
    last_gnt_d = last_gnt_q;
    gnt0_d     = gnt0_q;
    gnt1_d     = gnt1_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    oe_d       = oe_q;
    nrd_d      = nrd_q;
    nwr_d      = nwr_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          addr_d     = pick1 ? addr1  : addr0;
          dout_d     = pick1 ? wdata1 : wdata0;
          op_we_d    = pick1 ? we1    : we0;
          oe_d       = pick1 ? we1    : we0;
          gnt0_d     = !pick1;
          gnt1_d     = pick1;
          last_gnt_d = pick1;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        nrd_d   = op_we_q;
        nwr_d   = !op_we_q;
        wcnt_d  = '0;
        state_d = STROBE;
      end
      STROBE: begin
        if (wcnt_q == WS_LAST) begin
          nrd_d   = 1'b1;
          nwr_d   = 1'b1;
          ack0_d  = gnt0_q;
          ack1_d  = gnt1_q;
          if (!op_we_q) begin
            rdata_d = memDataIn;
          end
          state_d = DONE;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      DONE: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        oe_d    = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!notReset) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      op_we_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata_q    <= '0;
      addr_q     <= '0;
      dout_q     <= '0;
      oe_q       <= 1'b0;
      nrd_q      <= 1'b1;
      nwr_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      op_we_q    <= op_we_d;
      last_gnt_q <= last_gnt_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      oe_q       <= oe_d;
      nrd_q      <= nrd_d;
      nwr_q      <= nwr_d;
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign rdata       = rdata_q;
  assign memAddr     = addr_q;
  assign memDataOut  = dout_q;
  assign memDataOE   = oe_q;
  assign memNotRead  = nrd_q;
  assign memNotWrite = nwr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (WAIT_STATES 1, 0, 15) share stimulus;
// expected accesses are queued when driven and retired on each ack.
module tb_mem_arbiter;
  localparam int N = 3;

  logic        clock = 1'b0;
  logic        notReset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;

  logic        ack0_o [N];
  logic        ack1_o [N];
  logic        gnt0_o [N];
  logic        gnt1_o [N];
  logic        oe     [N];
  logic        nrd    [N];
  logic        nwr    [N];
  logic [15:0] rdata  [N];
  logic [15:0] maddr  [N];
  logic [15:0] mdout  [N];
  logic [15:0] mdin   [N];
  logic [15:0] sram   [0:65535];

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    bit          port;
    bit          we;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  int unsigned ack_t[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign mdin[g] = sram[maddr[g]];
    mem_arbiter #(
      .ADDR_WIDTH (16),
      .DATA_WIDTH (16),
      .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 0 : 15))
    ) u_dut (
      .clock      (clock),
      .notReset   (notReset),
      .req0       (req0),
      .req1       (req1),
      .we0        (we0),
      .we1        (we1),
      .addr0      (addr0),
      .addr1      (addr1),
      .wdata0     (wdata0),
      .wdata1     (wdata1),
      .ack0       (ack0_o[g]),
      .ack1       (ack1_o[g]),
      .gnt0       (gnt0_o[g]),
      .gnt1       (gnt1_o[g]),
      .rdata      (rdata[g]),
      .memAddr    (maddr[g]),
      .memDataOut (mdout[g]),
      .memDataOE  (oe[g]),
      .memDataIn  (mdin[g]),
      .memNotRead (nrd[g]),
      .memNotWrite(nwr[g])
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 15);
  endfunction

  task automatic do_reset();
    @(negedge clock);
    notReset = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clock);
    @(negedge clock);
    notReset = 1'b1;
  endtask

  task automatic drive(input bit port, input bit we, input logic [15:0] a,
                       input logic [15:0] wd, input logic [15:0] exp_data);
    exp_t e;
    if (port) begin
      we1 = we; addr1 = a; wdata1 = wd; req1 = 1'b1;
    end else begin
      we0 = we; addr0 = a; wdata0 = wd; req0 = 1'b1;
    end
    e.port = port; e.we = we; e.addr = a; e.data = exp_data;
    sb.push_back(e);
  endtask

  // Watches instance d for nacks acknowledged accesses, retiring scoreboard entries.
  task automatic monitor(input int d, input int nacks, input int budget, input bit drop_in_strobe);
    int          seen = 0;
    int          rd_w = 0;
    int          wr_w = 0;
    int          oe_w = 0;
    bit          prev_ack = 1'b0;
    logic [15:0] sa = '0;
    logic [15:0] sd = '0;
    exp_t        e;
    int          ws = ws_of(d);
    ack_t.delete();
    for (int c = 0; c < budget && seen < nacks; c++) begin
      @(negedge clock);
      checks++;
      if ((!nrd[d] && !nwr[d]) || (oe[d] && !nrd[d]) || (gnt0_o[d] && gnt1_o[d])) begin
        errors++;
        $display("FAIL bus_excl: nrd=%b nwr=%b oe=%b gnt0=%b gnt1=%b, required no overlap",
                 nrd[d], nwr[d], oe[d], gnt0_o[d], gnt1_o[d]);
      end
      if (!nrd[d] || !nwr[d]) begin
        sa = maddr[d];
        sd = mdout[d];
        if (drop_in_strobe) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
      if (!nrd[d]) rd_w++;
      if (!nwr[d]) wr_w++;
      if (oe[d]) oe_w++;
      if (ack0_o[d] || ack1_o[d]) begin
        checks++;
        if (prev_ack) begin
          errors++;
          $display("FAIL ack_pulse: ack high 2 cycles in a row, required 1");
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_empty: ack with no access pending");
        end else begin
          e = sb.pop_front();
          checks++;
          if ({ack1_o[d], ack0_o[d]} !== (e.port ? 2'b10 : 2'b01) ||
              {gnt1_o[d], gnt0_o[d]} !== (e.port ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL ack_port: ack=%b%b gnt=%b%b, required port %0d only",
                     ack1_o[d], ack0_o[d], gnt1_o[d], gnt0_o[d], e.port);
          end
          checks++;
          if ((e.we ? wr_w : rd_w) != ws + 1 || (e.we ? rd_w : wr_w) != 0) begin
            errors++;
            $display("FAIL strobe_width: rd=%0d wr=%0d, required %0d on %s",
                     rd_w, wr_w, ws + 1, e.we ? "write" : "read");
          end
          checks++;
          if (sa !== e.addr) begin
            errors++;
            $display("FAIL mem_addr: got %h, required %h", sa, e.addr);
          end
          checks++;
          if (e.we) begin
            if (sd !== e.data || oe_w != ws + 3) begin
              errors++;
              $display("FAIL write_bus: data %h oe_cycles %0d, required %h and %0d",
                       sd, oe_w, e.data, ws + 3);
            end
            sram[sa] = sd;
          end else if (rdata[d] !== e.data) begin
            errors++;
            $display("FAIL rdata: got %h, required %h", rdata[d], e.data);
          end
        end
        ack_t.push_back(cyc);
        seen++;
        rd_w = 0;
        wr_w = 0;
        oe_w = 0;
        if (seen == nacks) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
      prev_ack = ack0_o[d] || ack1_o[d];
    end
    checks++;
    if (seen < nacks) begin
      errors++;
      $display("FAIL timeout: %0d acks, required %0d", seen, nacks);
      req0 = 1'b0;
      req1 = 1'b0;
    end else begin
      @(negedge clock);
      if (ack0_o[d] || ack1_o[d]) begin
        errors++;
        $display("FAIL ack_pulse_end: ack=%b%b after final ack, required 00", ack1_o[d], ack0_o[d]);
      end
    end
  endtask

  task automatic check_latency(input int idx, input int unsigned t0, input int want);
    checks++;
    if (ack_t.size() <= idx) begin
      errors++;
      $display("FAIL latency%0d: no ack recorded, required %0d", idx, want);
    end else if (int'(ack_t[idx] - (t0 + 1)) != want) begin
      errors++;
      $display("FAIL latency%0d: got %0d, required %0d", idx, int'(ack_t[idx] - (t0 + 1)), want);
    end
  endtask

  task automatic test_reset();
    notReset = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0040;
    repeat (2) @(negedge clock);
    for (int d = 0; d < N; d++) begin
      checks++;
      if (nrd[d] !== 1'b1 || nwr[d] !== 1'b1 || oe[d] !== 1'b0 || ack0_o[d] !== 1'b0 ||
          ack1_o[d] !== 1'b0 || gnt0_o[d] !== 1'b0 || gnt1_o[d] !== 1'b0 ||
          rdata[d] !== 16'h0000 || maddr[d] !== 16'h0000 || mdout[d] !== 16'h0000) begin
        errors++;
        $display("FAIL reset%0d: nrd=%b nwr=%b oe=%b ack=%b%b gnt=%b%b rdata=%h addr=%h dout=%h, required 1 1 0 00 00 0 0 0",
                 d, nrd[d], nwr[d], oe[d], ack1_o[d], ack0_o[d], gnt1_o[d], gnt0_o[d],
                 rdata[d], maddr[d], mdout[d]);
      end
    end
    req0 = 1'b0;
    notReset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_read();
    int unsigned t0;
    do_reset();
    t0 = cyc;
    drive(1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF);
    monitor(0, 1, 20, 1'b0);
    check_latency(0, t0, 3);
  endtask

  task automatic test_write();
    do_reset();
    drive(1'b1, 1'b1, 16'h1234, 16'hA5A5, 16'hA5A5);
    monitor(0, 1, 20, 1'b0);
    checks++;
    if (sram[16'h1234] !== 16'hA5A5) begin
      errors++;
      $display("FAIL sram_write: got %h, required a5a5", sram[16'h1234]);
    end
  endtask

  task automatic test_contention();
    int unsigned t0;
    do_reset();
    t0 = cyc;
    drive(1'b0, 1'b0, 16'h0200, 16'h0000, 16'h1111);
    drive(1'b1, 1'b0, 16'h0300, 16'h0000, 16'h2222);
    sb.push_back(sb[0]);
    sb.push_back(sb[1]);
    monitor(0, 4, 40, 1'b0);
    check_latency(0, t0, 3);
    for (int i = 1; i < 4; i++) check_latency(i, t0, 3 + 5 * i);
  endtask

  task automatic test_reset_mid_access();
    bit hit = 1'b0;
    do_reset();
    drive(1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF);
    for (int c = 0; c < 10 && !hit; c++) begin
      @(negedge clock);
      hit = !nrd[0];
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL strobe_seen: memNotRead never low, required low within 10 cycles");
    end
    notReset = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0300;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      checks++;
      if (nrd[0] !== 1'b1 || nwr[0] !== 1'b1 || ack0_o[0] !== 1'b0 || ack1_o[0] !== 1'b0 ||
          gnt0_o[0] !== 1'b0 || gnt1_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL abort%0d: nrd=%b nwr=%b ack=%b%b gnt=%b%b, required 1 1 00 00",
                 c, nrd[0], nwr[0], ack1_o[0], ack0_o[0], gnt1_o[0], gnt0_o[0]);
      end
    end
    notReset = 1'b1;
    @(negedge clock);
    checks++;
    if (gnt0_o[0] !== 1'b1 || gnt1_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL tie_after_reset: gnt=%b%b, required 01", gnt1_o[0], gnt0_o[0]);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    sb.delete();
    drive(1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF);
    req0 = 1'b0;
    monitor(0, 1, 20, 1'b0);
  endtask

  task automatic test_wait_extremes();
    int unsigned t0;
    for (int d = 1; d < N; d++) begin
      do_reset();
      sb.delete();
      t0 = cyc;
      drive(1'b0, 1'b0, 16'h0100, 16'h0000, 16'h7FFF);
      monitor(d, 1, 40, d == 2);
      check_latency(0, t0, 2 + ws_of(d));
    end
  endtask

  initial begin
    sram[16'h0040] = 16'hBEEF;
    sram[16'h0100] = 16'h7FFF;
    sram[16'h0200] = 16'h1111;
    sram[16'h0300] = 16'h2222;
    test_reset();
    test_read();
    test_write();
    test_contention();
    test_reset_mid_access();
    test_wait_extremes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

endmodule
